// File: rtl/vote_hist.sv
// Vote histogram: accumulates per-bin classification votes into saturating
// counters, freezes them for the max scanner, then clears and re-arms.
module vote_hist #(
  parameter int NUM       = 18,
  parameter int CW        = 7,
  parameter int FRAME_LEN = 100,
  parameter int SCAN_TO   = 63
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_vote_valid,
  input  logic [4:0]        i_vote_idx,
  input  logic              i_frame_end,
  input  logic              i_scan_done,
  output logic              o_ready,
  output logic [NUM*CW-1:0] o_cnt,
  output logic              o_scan_en,
  output logic [7:0]        o_total,
  output logic              o_err
);

  localparam int SW = $clog2(SCAN_TO + 1);

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_SCAN,
    ST_CLEAR
  } state_e;

  state_e        state_q;
  logic [SW-1:0] scan_cnt_q;
  logic [CW-1:0] cnt_q [NUM];
  logic [CW-1:0] cnt_d [NUM];
  logic [7:0]    total_q;
  logic [7:0]    total_d;
  logic [7:0]    total_inc;
  logic          ready_q;
  logic          scan_en_q;
  logic          err_q;

  logic          idx_in_range;
  logic          vote_ok;
  logic          close_frame;
  logic          scan_timeout;
  logic          err_event;

  // NOTE: combinational blocks use blocking '=' so later lines see the values
  // just computed; only clocked blocks use '<='.
  always_comb begin
    idx_in_range = ({1'b0, i_vote_idx} < 6'(NUM));
    vote_ok      = (state_q == ST_ACCUM) && i_vote_valid && idx_in_range;
    total_inc    = total_q + 8'd1;
    close_frame  = (state_q == ST_ACCUM) &&
                   (i_frame_end || (vote_ok && (total_inc == 8'(FRAME_LEN))));
    scan_timeout = (state_q == ST_SCAN) && !i_scan_done &&
                   (scan_cnt_q == SW'(SCAN_TO - 1));
    // Any number of coincident error causes collapse into one pulse.
    err_event    = (i_vote_valid && ((state_q != ST_ACCUM) || !idx_in_range)) ||
                   scan_timeout;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    total_d = total_q;
    if (state_q == ST_CLEAR) begin
      for (int k = 0; k < NUM; k++) begin
        cnt_d[k] = '0;
      end
      total_d = '0;
    end else if (vote_ok) begin
      // Total counts every accepted vote, even when its bin is already full.
      total_d = total_inc;
      for (int k = 0; k < NUM; k++) begin
        if ((i_vote_idx == 5'(k)) && (cnt_q[k] != {CW{1'b1}})) begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  // NOTE: the bin counters are ordinary flops whose zero state is visible on
  // o_cnt, so unlike a RAM they are reset along with the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ACCUM;
      scan_cnt_q <= '0;
      ready_q    <= 1'b1;
      scan_en_q  <= 1'b0;
      err_q      <= 1'b0;
      total_q    <= '0;
      for (int k = 0; k < NUM; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      err_q   <= err_event;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      unique case (state_q)
        ST_ACCUM: begin
          if (close_frame) begin
            state_q    <= ST_SCAN;
            scan_cnt_q <= '0;
            ready_q    <= 1'b0;
            scan_en_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (i_scan_done || scan_timeout) begin
            state_q   <= ST_CLEAR;
            scan_en_q <= 1'b0;
          end else begin
            scan_cnt_q <= scan_cnt_q + SW'(1);
          end
        end
        ST_CLEAR: begin
          state_q <= ST_ACCUM;
          ready_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_ACCUM;
          ready_q   <= 1'b1;
          scan_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_cnt = '0;
    for (int k = 0; k < NUM; k++) begin
      o_cnt[k*CW +: CW] = cnt_q[k];
    end
  end

  assign o_ready   = ready_q;
  assign o_scan_en = scan_en_q;
  assign o_total   = total_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_vote_hist.sv
// Directed bench for vote_hist: a vote model pushes each expected frozen frame
// to a scoreboard that is compared when the scan enable rises.
module tb_vote_hist;

  localparam int NUM = 18;
  localparam int CW  = 7;
  localparam int FL  = 100;
  localparam int TO  = 63;
  localparam int VW  = NUM * CW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;

  logic          vote_valid = 1'b0;
  logic [4:0]    vote_idx = '0;
  logic          frame_end = 1'b0;
  logic          scan_done = 1'b0;
  logic          o_ready;
  logic [VW-1:0] o_cnt;
  logic          o_scan_en;
  logic [7:0]    o_total;
  logic          o_err;

  logic          s_vote_valid = 1'b0;
  logic [4:0]    s_vote_idx = '0;
  logic          s_frame_end = 1'b0;
  logic          s_scan_done = 1'b0;
  logic          s_ready;
  logic [VW-1:0] s_cnt;
  logic          s_scan_en;
  logic [7:0]    s_total;
  logic          s_err;

  always #5 clk = ~clk;

  vote_hist #(.NUM(NUM), .CW(CW), .FRAME_LEN(FL), .SCAN_TO(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_vote_valid(vote_valid), .i_vote_idx(vote_idx),
    .i_frame_end(frame_end), .i_scan_done(scan_done),
    .o_ready(o_ready), .o_cnt(o_cnt), .o_scan_en(o_scan_en),
    .o_total(o_total), .o_err(o_err)
  );

  // Second instance with a long frame so saturation can be reached.
  vote_hist #(.NUM(NUM), .CW(CW), .FRAME_LEN(255), .SCAN_TO(TO)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .i_vote_valid(s_vote_valid), .i_vote_idx(s_vote_idx),
    .i_frame_end(s_frame_end), .i_scan_done(s_scan_done),
    .o_ready(s_ready), .o_cnt(s_cnt), .o_scan_en(s_scan_en),
    .o_total(s_total), .o_err(s_err)
  );

  typedef struct packed {
    logic [VW-1:0] cnt;
    logic [7:0]    total;
  } frame_t;

  frame_t sb_q[$];
  int     exp_bin[NUM];
  int     exp_total = 0;
  int     checks = 0;
  int     errors = 0;
  logic   scan_en_prev = 1'b0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < NUM; k++) v[k*CW +: CW] = CW'(exp_bin[k]);
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NUM; k++) exp_bin[k] = 0;
    exp_total = 0;
  endtask

  task automatic tick();
    frame_t f;
    @(posedge clk);
    #1;
    if (o_scan_en && !scan_en_prev) begin
      check("sb_frame_expected", VW'(sb_q.size() != 0), VW'(1));
      if (sb_q.size() != 0) begin
        f = sb_q.pop_front();
        check("sb_cnt", o_cnt, f.cnt);
        check("sb_total", VW'(o_total), VW'(f.total));
      end
    end
    scan_en_prev = o_scan_en;
  endtask

  task automatic cycle(input bit v, input int idx, input bit fe, input bit done);
    vote_valid = v;
    vote_idx   = 5'(idx);
    frame_end  = fe;
    scan_done  = done;
    tick();
    vote_valid = 1'b0;
    vote_idx   = '0;
    frame_end  = 1'b0;
    scan_done  = 1'b0;
  endtask

  // One cycle in ACCUM: update the model, push the frame if it closes.
  task automatic accum_cycle(input bit v, input int idx, input bit fe);
    bit     accepted;
    frame_t f;
    accepted = v && (idx < NUM);
    if (accepted) begin
      if (exp_bin[idx] < (1 << CW) - 1) exp_bin[idx]++;
      exp_total++;
    end
    if (fe || (accepted && exp_total == FL)) begin
      f.cnt   = model_vec();
      f.total = 8'(exp_total);
      sb_q.push_back(f);
      model_clear();
    end
    cycle(v, idx, fe, 1'b0);
  endtask

  task automatic finish_scan();
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("clear_scan_en", VW'(o_scan_en), VW'(0));
    check("clear_ready", VW'(o_ready), VW'(0));
    tick();
    check("rearm_ready", VW'(o_ready), VW'(1));
    check("rearm_cnt", o_cnt, '0);
    check("rearm_total", VW'(o_total), VW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] frozen;
    logic          seen;
    int            best_i;
    int            best_v;

    model_clear();
    tick();
    tick();
    check("rst_ready", VW'(o_ready), VW'(1));
    check("rst_scan_en", VW'(o_scan_en), VW'(0));
    check("rst_err", VW'(o_err), VW'(0));
    check("rst_total", VW'(o_total), VW'(0));
    check("rst_cnt", o_cnt, '0);
    reset_n = 1'b1;
    tick();

    // Votes 3,3,5 then frame_end; nominal scan with done after NUM+1 cycles.
    accum_cycle(1'b1, 3, 1'b0);
    accum_cycle(1'b1, 3, 1'b0);
    accum_cycle(1'b1, 5, 1'b0);
    check("t1_total", VW'(o_total), VW'(3));
    accum_cycle(1'b0, 0, 1'b1);
    check("t1_scan_en", VW'(o_scan_en), VW'(1));
    check("t1_ready", VW'(o_ready), VW'(0));
    best_i = 0;
    best_v = 0;
    for (int k = 0; k < NUM; k++) begin
      if (int'(o_cnt[k*CW +: CW]) > best_v) begin
        best_v = int'(o_cnt[k*CW +: CW]);
        best_i = k;
      end
    end
    check("t1_max_idx", VW'(best_i), VW'(3));
    check("t1_max_val", VW'(best_v), VW'(2));
    frozen = o_cnt;
    seen = 1'b0;
    repeat (NUM) begin
      tick();
      if (o_cnt !== frozen || o_scan_en !== 1'b1) seen = 1'b1;
    end
    check("t1_scan_stable", VW'(seen), VW'(0));
    finish_scan();

    // Saturation on a 255-vote frame: 130 votes to bin 0.
    s_vote_valid = 1'b1;
    s_vote_idx   = 5'd0;
    repeat (130) tick();
    s_vote_valid = 1'b0;
    tick();
    check("t2_bin0_sat", VW'(s_cnt[CW-1:0]), VW'(127));
    check("t2_total", VW'(s_total), VW'(130));
    check("t2_still_accum", VW'(s_ready), VW'(1));

    // 100 spread votes auto-close the frame; the 100th vote is counted.
    for (int i = 0; i < FL; i++) begin
      accum_cycle(1'b1, i % NUM, 1'b0);
      if (i == FL - 2) check("t3_open_before_last", VW'(o_ready), VW'(1));
    end
    check("t3_scan_en", VW'(o_scan_en), VW'(1));
    check("t3_ready", VW'(o_ready), VW'(0));
    tick();
    tick();
    finish_scan();

    // Out-of-range index, then a vote and a frame_end during SCAN.
    accum_cycle(1'b1, 7, 1'b0);
    frozen = model_vec();
    accum_cycle(1'b1, 20, 1'b0);
    check("t4_bad_err", VW'(o_err), VW'(1));
    check("t4_bad_total", VW'(o_total), VW'(1));
    check("t4_bad_cnt", o_cnt, frozen);
    accum_cycle(1'b0, 0, 1'b0);
    check("t4_err_pulse", VW'(o_err), VW'(0));
    accum_cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 2, 1'b0, 1'b0);
    check("t4_scan_drop_err", VW'(o_err), VW'(1));
    check("t4_scan_drop_cnt", o_cnt, frozen);
    check("t4_scan_drop_total", VW'(o_total), VW'(1));
    cycle(1'b0, 0, 1'b1, 1'b0);
    check("t4_fe_ignored", VW'(o_scan_en), VW'(1));
    check("t4_err_cleared", VW'(o_err), VW'(0));
    finish_scan();

    // Scan timeout with i_scan_done held low.
    accum_cycle(1'b1, 1, 1'b0);
    accum_cycle(1'b0, 0, 1'b1);
    seen = 1'b0;
    repeat (TO - 1) begin
      tick();
      if (o_err !== 1'b0) seen = 1'b1;
    end
    check("t5_no_early_err", VW'(seen), VW'(0));
    check("t5_still_scan", VW'(o_scan_en), VW'(1));
    tick();
    check("t5_timeout_err", VW'(o_err), VW'(1));
    check("t5_clear_scan_en", VW'(o_scan_en), VW'(0));
    tick();
    check("t5_rearm_ready", VW'(o_ready), VW'(1));
    check("t5_rearm_err", VW'(o_err), VW'(0));
    check("t5_rearm_cnt", o_cnt, '0);
    check("t5_rearm_total", VW'(o_total), VW'(0));

    // Async reset mid-scan, then a vote on the frame_end cycle.
    accum_cycle(1'b1, 4, 1'b0);
    accum_cycle(1'b1, 4, 1'b0);
    accum_cycle(1'b0, 0, 1'b1);
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_rst_scan_en", VW'(o_scan_en), VW'(0));
    check("t6_rst_cnt", o_cnt, '0);
    check("t6_rst_ready", VW'(o_ready), VW'(1));
    check("t6_rst_total", VW'(o_total), VW'(0));
    tick();
    reset_n = 1'b1;
    model_clear();
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("t6_done_ignored", VW'(o_ready), VW'(1));
    accum_cycle(1'b1, 9, 1'b1);
    check("t6_vote_fe_scan", VW'(o_scan_en), VW'(1));
    finish_scan();

    check("sb_drained", VW'(sb_q.size()), VW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
